cpu_sequencer: RTL
==================

# cpu_sequencer

Phase controller that sequences the CPU's two-entry operand register file and the clocked ALU through load, execute, output and idle phases for one operation at a time. It accepts an operation request, writes both operands into the register file, reads them back, runs the ALU and holds the result until the consumer accepts it. The existing phase encoding is driven on `phase` so that the top level and debug logic see the same load/exec/output/idle codes.

## Interface
- `DATA_W`, default 4: operand, register and ALU data width.
- `OP_W`, default 3: ALU opcode width.
- `ALU_LAT`, default 1, minimum 1: cycles from the `alu_en` cycle until `alu_out` is valid.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  operation request; accepted only in IDLE.
- `op_in`  in  OP_W  opcode; sampled when `start` is accepted.
- `a_in`  in  DATA_W  operand A; sampled when `start` is accepted.
- `b_in`  in  DATA_W  operand B; sampled when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `phase`  out  2  phase code: 00 load, 01 exec, 10 output, 11 idle.
- `reg_wr_en`  out  1  register file write enable.
- `reg_addr`  out  1  register file address.
- `reg_wdata`  out  DATA_W  register file write data.
- `reg_rdata`  in  DATA_W  register file read data; combinational read of `reg_addr`.
- `alu_en`  out  1  ALU enable.
- `alu_opcode`  out  OP_W  ALU opcode.
- `alu_a`, `alu_b`  out  DATA_W  ALU operands.
- `alu_out`  in  DATA_W  ALU result.
- `result`  out  DATA_W  captured ALU result.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.

## Operation
- States and `phase` mapping:
  - IDLE → 11.
  - LD_A, LD_B → 00.
  - RD_A, RD_B, EXEC → 01.
  - OUT → 10.
- IDLE:
  - If `start`=1, latch `op_in`, `a_in` and `b_in`, then go to LD_A.
  - Otherwise stay in IDLE.
- LD_A: `reg_wr_en`=1, `reg_addr`=0, `reg_wdata`=A; go to LD_B.
- LD_B: `reg_wr_en`=1, `reg_addr`=1, `reg_wdata`=B; go to RD_A.
- RD_A: `reg_addr`=0; capture `reg_rdata` into opA; go to RD_B.
- RD_B: `reg_addr`=1; capture `reg_rdata` into opB; go to EXEC.
- EXEC lasts ALU_LAT+1 cycles, timed by a down-counter of width clog2(ALU_LAT+1).
  - `alu_en`=1 in the first EXEC cycle only.
  - `alu_opcode`, `alu_a` (opA) and `alu_b` (opB) are held stable for the whole of EXEC.
  - `alu_out` is captured into `result` at the end of the last EXEC cycle; go to OUT.
- OUT: `result_valid`=1.
  - If `result_ready`=1, go to IDLE.
  - Otherwise hold OUT with `result` stable.
- Outputs not named in a state are driven to 0: `reg_wr_en`, `reg_addr`, `reg_wdata`, `alu_en`, `alu_opcode`, `alu_a`, `alu_b`.
- The block performs no arithmetic itself. Data passes through unmodified; only DATA_W-bit values are stored.

## Timing
- Reset values: state IDLE, `phase`=11, `busy`=0, `result`=0, `result_valid`=0. All register and ALU control outputs are 0, and all latched operands are 0.
- Take the cycle in which `start` is accepted as T:
  - LD_A at T+1, LD_B at T+2.
  - RD_A at T+3, RD_B at T+4.
  - EXEC from T+5 to T+5+ALU_LAT.
  - `result_valid` first high at T+6+ALU_LAT (T+7 for the default).
- Handshake:
  - The result transfers on the edge where `result_valid`=`result_ready`=1.
  - IDLE follows on the next cycle.
  - `result` keeps its value in IDLE until the next capture; `result_valid` is low in IDLE.
- A new `start` can be accepted no earlier than the first IDLE cycle. Minimum issue interval is 7+ALU_LAT cycles with `result_ready` tied high.
- `start` while `busy`=1 is ignored, and no state is latched.
- Changes to `op_in`, `a_in` or `b_in` after acceptance have no effect on the operation in flight.
- `result_ready` outside OUT is ignored.
- `rst` asserted in any state forces the reset values immediately. The operation in flight is discarded and is not resumed when reset releases.
- First edge after reset release: IDLE; a `start` present on that edge is accepted.

## Structure
- Shared package `cpu_pkg` holds:
  - Phase code constants PH_LOAD=00, PH_EXEC=01, PH_OUT=10, PH_IDLE=11, shared with the CPU top.
  - The sequencer state enum.
  - Default DATA_W and OP_W constants.
- Single module: FSM, EXEC latency counter and operand/result registers.
- No sub-module is warranted; the counter is a few lines and stays inline.

## Test plan
- Bench ALU model returns a+b for opcode 000 with ALU_LAT=1.
  - Stimulus: start with A=3, B=5 and `result_ready` high.
  - Required: `result`=8 with `result_valid` first high at T+7.
  - Required: `phase` sequence 11,00,00,01,01,01,01,10,11.
- Register file traffic:
  - Check writes (addr 0, data A) at T+1 and (addr 1, data B) at T+2.
  - Check reads at T+3 and T+4, and exactly one `alu_en` pulse at T+5.
- Backpressure:
  - Hold `result_ready` low for 10 cycles in OUT.
  - Required: `result` and `result_valid` stable throughout; IDLE one cycle after `result_ready` rises.
- `start` pulsed during LD_B and during OUT:
  - Required: both ignored, no second operation, `busy` falls only after the handshake.
- Assert `rst` during EXEC:
  - Required: all outputs reset immediately and `phase`=11.
  - Required: after release, start with A=15, B=1 gives 0 (4-bit wrap) at T+7.
- ALU_LAT=3 build:
  - Required: `alu_en` is a single cycle and `result_valid` first rises at T+9.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the CPU slice: the externally visible phase codes
// (also decoded by the CPU top and the debug logic), the sequencer state
// enumeration and the default data/opcode widths.
package cpu_pkg;

    // Phase codes driven on the sequencer 'phase' output.
    localparam logic [1:0] PH_LOAD = 2'b00;
    localparam logic [1:0] PH_EXEC = 2'b01;
    localparam logic [1:0] PH_OUT  = 2'b10;
    localparam logic [1:0] PH_IDLE = 2'b11;

    // Default widths of the operand/result datapath and the ALU opcode.
    localparam int DEF_DATA_W = 4;
    localparam int DEF_OP_W   = 3;

    // Sequencer states. Several states share one phase code; see the
    // phase assignments in cpu_sequencer.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_A,
        ST_LD_B,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_OUT
    } seq_state_t;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Runs one ALU operation at a time: writes operands A and B into the
// two-entry register file, reads them back, drives the clocked ALU and holds
// the result until the consumer takes it.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start, op_in, a_in, b_in   operation request (sampled in IDLE only)
//   busy, phase                status: busy outside IDLE, phase code
//   reg_wr_en, reg_addr,
//   reg_wdata, reg_rdata       register file port (combinational read)
//   alu_en, alu_opcode,
//   alu_a, alu_b, alu_out      clocked ALU port
//   result, result_valid,
//   result_ready               result handshake
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   op_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic [1:0]        phase,
    output logic              reg_wr_en,
    output logic              reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              alu_en,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready
);

    // EXEC lasts ALU_LAT+1 cycles: the counter is loaded with ALU_LAT on
    // entry and the result is captured in the cycle it reads zero.
    localparam int              CNT_W    = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT);

    seq_state_t        state;
    logic [CNT_W-1:0]  exec_cnt;
    logic [OP_W-1:0]   op_lat;
    logic [DATA_W-1:0] a_lat;
    logic [DATA_W-1:0] b_lat;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Sequencer FSM with the operand, result and status registers. busy and
    // phase are updated together with the state so they never lag it. The
    // request is latched only on acceptance in IDLE, so later changes on the
    // inputs and any start seen while busy leave the operation untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            phase        <= PH_IDLE;
            busy         <= 1'b0;
            exec_cnt     <= '0;
            op_lat       <= '0;
            a_lat        <= '0;
            b_lat        <= '0;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_lat <= op_in;
                        a_lat  <= a_in;
                        b_lat  <= b_in;
                        state  <= ST_LD_A;
                        phase  <= PH_LOAD;
                        busy   <= 1'b1;
                    end
                end
                ST_LD_A: begin
                    state <= ST_LD_B;
                end
                ST_LD_B: begin
                    state <= ST_RD_A;
                    phase <= PH_EXEC;
                end
                ST_RD_A: begin
                    op_a  <= reg_rdata;
                    state <= ST_RD_B;
                end
                ST_RD_B: begin
                    op_b     <= reg_rdata;
                    exec_cnt <= CNT_INIT;
                    state    <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (exec_cnt == '0) begin
                        result       <= alu_out;
                        result_valid <= 1'b1;
                        state        <= ST_OUT;
                        phase        <= PH_OUT;
                    end else begin
                        exec_cnt <= exec_cnt - CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= ST_IDLE;
                        phase        <= PH_IDLE;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    state        <= ST_IDLE;
                    phase        <= PH_IDLE;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    // Register-file and ALU port decode. Every field is a pure function of
    // registered state, so the ports stay at zero outside the states that use
    // them. alu_en fires only while the counter still holds its load value,
    // i.e. the first EXEC cycle, while operands and opcode stay up throughout.
    always_comb begin
        reg_wr_en  = 1'b0;
        reg_addr   = 1'b0;
        reg_wdata  = '0;
        alu_en     = 1'b0;
        alu_opcode = '0;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            ST_LD_A: begin
                reg_wr_en = 1'b1;
                reg_addr  = 1'b0;
                reg_wdata = a_lat;
            end
            ST_LD_B: begin
                reg_wr_en = 1'b1;
                reg_addr  = 1'b1;
                reg_wdata = b_lat;
            end
            ST_RD_A: begin
                reg_addr = 1'b0;
            end
            ST_RD_B: begin
                reg_addr = 1'b1;
            end
            ST_EXEC: begin
                alu_en     = (exec_cnt == CNT_INIT);
                alu_opcode = op_lat;
                alu_a      = op_a;
                alu_b      = op_b;
            end
            default: begin
            end
        endcase
    end

endmodule
